proj_sweep_ctrl: RTL and testbench
==================================

// Module: proj_sweep_ctrl
// PURPOSE
//  Sequences the pressure-projection solve over the velocity field. Walks every cell NUM_ITERS
//  times, drives field_x/field_y plus a start pulse into the per-cell velocity reader, and waits
//  for its done. Hands each non-isolated cell to the update/write-back unit over a valid/ready
//  handshake. Sits between the top-level sim FSM and the reader/updater pair.
// PARAMETERS
//  FIELD_WIDTH   8    cells per row
//  FIELD_HEIGHT  6    rows
//  NUM_ITERS     40   sweeps per solve (>=1)
//  ITER_W        $clog2(NUM_ITERS+1)  width of the iteration index
// PORTS
//  clk         in   1       system clock
//  rst         in   1       asynchronous, active-high reset
//  go          in   1       start a solve; sampled only in IDLE
//  abort       in   1       cancel the solve in progress
//  busy        out  1       high from the cycle after go until solve_done/abort completes
//  solve_done  out  1       1-cycle pulse when all sweeps finish (not on abort)
//  field_x     out  32      cell column presented to the reader
//  field_y     out  32      cell row presented to the reader
//  rd_start    out  1       1-cycle start pulse to the reader
//  rd_done     in   1       reader finished; rd_n valid this cycle
//  rd_n        in   3       count of non-wall faces of the current cell (0..4)
//  upd_valid   out  1       cell ready for update; held until upd_ready
//  upd_ready   in   1       updater accepts the cell
//  upd_x/upd_y out  32      coordinates of the handed-off cell (equal field_x/field_y)
//  upd_last    out  1       qualifies upd_valid: last cell of the last sweep
//  iter_idx    out  ITER_W  current sweep, 0-based
//  skip_cnt    out  16      cells skipped (rd_n==0) this solve; saturates at 0xFFFF
// BEHAVIOUR
//  Reset: state IDLE; every output 0, including field_x/y, iter_idx and skip_cnt.
//  FSM: IDLE -go-> ISSUE (clear coords, iter_idx, skip_cnt; busy=1).
//   ISSUE: assert rd_start for exactly 1 cycle with field_x/y stable -> WAIT_RD.
//   WAIT_RD: field_x/y held stable. On rd_done:
//     rd_n==0 -> ADVANCE; skip_cnt+1.
//     rd_n!=0 -> HANDOFF.
//   HANDOFF: upd_valid=1 and upd_x/y/upd_last stable until upd_ready; on valid&&ready -> ADVANCE.
//   ADVANCE (1 cycle): x++; at x==FIELD_WIDTH-1, x=0 and y++; at the last row, y=0 and iter_idx++.
//     After the final cell of sweep NUM_ITERS-1 -> FIN, else -> ISSUE.
//   FIN: solve_done=1 for 1 cycle, busy=0 -> IDLE. Coordinates retain the last cell.
//  Reader latency is not assumed; rd_done may arrive any number of cycles after rd_start.
//  rd_done outside WAIT_RD is ignored. go while busy is ignored.
//  abort (any state except IDLE):
//   - In ISSUE/ADVANCE/HANDOFF: go to IDLE next cycle; upd_valid drops.
//   - In WAIT_RD: wait for rd_done, then go to IDLE, so no stale done is left behind.
//   - No solve_done pulse on abort.
//  abort and go asserted together in IDLE: go wins.
//  Reset mid-solve: immediate return to IDLE with all outputs 0. The updater must tolerate
//   a dropped upd_valid.
//  Per-cell throughput with a 3-cycle reader and upd_ready=1: ISSUE 1 + WAIT_RD 3 + HANDOFF 1
//   + ADVANCE 1 = 6 cycles.
// CONFIGURATION
//  RED_BLACK_EN defined: each sweep runs two passes, pass 0 over cells with (x+y) even, then
//   pass 1 over (x+y) odd.
//   - x steps by 2; each row's start column = (y+pass)&1.
//   - iter_idx increments only after pass 1.
//   - upd_last is set on the last odd cell.
//   - Adds output pass (1 bit, reset 0).
//  RED_BLACK_EN undefined: plain raster order (x fastest); no pass port.
// STRUCTURE
//  fluid_pkg: FIELD_WIDTH/FIELD_HEIGHT defaults, VEL_DATAW=33, the sweep_state_t enum
//   {IDLE,ISSUE,WAIT_RD,HANDOFF,ADVANCE,FIN}.
//  Sub-module cell_iter: x/y/iter(/pass) counter. Inputs step and clear; outputs coordinates,
//   last_cell and last_of_solve. Holds all wrap and parity logic.
//  Top level: FSM, handshake, skip counter.
// TESTING
//  1. 8x6, NUM_ITERS=1, reader done 3 cycles after start, rd_n=4, upd_ready=1
//     -> 48 handoffs in raster order, upd_last only at (7,5), solve_done once at cycle 288+-2.
//  2. Same, rd_n=0 for cell (3,2) -> 47 handoffs, skip_cnt=1, (3,2) never on upd_x/upd_y.
//  3. upd_ready low for 10 cycles at cell (0,1)
//     -> upd_valid and upd_x/y stay stable; no rd_start is issued during the stall.
//  4. abort in WAIT_RD with rd_done delayed 5 cycles
//     -> IDLE 1 cycle after rd_done; no solve_done; a following go restarts at (0,0), iter 0.
//  5. NUM_ITERS=3 -> iter_idx reads 0,1,2; exactly 144 rd_start pulses; go during busy ignored.
//  6. RED_BLACK_EN, 4x2, NUM_ITERS=1
//     -> visit order (0,0),(2,0),(1,1),(3,1) then (1,0),(3,0),(0,1),(2,1); upd_last at (2,1).

Source files
------------

// File: rtl/proj_sweep_ctrl_pkg.sv
// Shared types and defaults for the projection sweep controller.
package proj_sweep_ctrl_pkg;

    localparam int FIELD_WIDTH  = 8;
    localparam int FIELD_HEIGHT = 6;
    localparam int VEL_DATAW    = 33;
    localparam int COORD_W      = 32;
    localparam int SKIP_W       = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT_RD = 3'd2,
        HANDOFF = 3'd3,
        ADVANCE = 3'd4,
        FIN     = 3'd5
    } sweep_state_t;

    function automatic logic [SKIP_W-1:0] sat_inc(input logic [SKIP_W-1:0] v);
        return (v == {SKIP_W{1'b1}}) ? v : v + SKIP_W'(1);
    endfunction

endpackage

// File: rtl/proj_sweep_ctrl_if.sv
// Reader (start/done) and updater (valid/ready) bundle between the sweep controller and its peers.
interface proj_sweep_ctrl_if;
    import proj_sweep_ctrl_pkg::*;

    logic [COORD_W-1:0] field_x;
    logic [COORD_W-1:0] field_y;
    logic               rd_start;
    logic               rd_done;
    logic [2:0]         rd_n;
    logic               upd_valid;
    logic               upd_ready;
    logic [COORD_W-1:0] upd_x;
    logic [COORD_W-1:0] upd_y;
    logic               upd_last;

    modport master (
        output field_x, field_y, rd_start, upd_valid, upd_x, upd_y, upd_last,
        input  rd_done, rd_n, upd_ready
    );

    modport slave (
        input  field_x, field_y, rd_start, upd_valid, upd_x, upd_y, upd_last,
        output rd_done, rd_n, upd_ready
    );

endinterface

// File: rtl/proj_sweep_ctrl_cell_iter.sv
// Cell walker: x/y/iteration counters with all wrap logic; parity passes when RED_BLACK_EN is defined.
module proj_sweep_ctrl_cell_iter
    import proj_sweep_ctrl_pkg::*;
#(
    parameter int FIELD_WIDTH  = proj_sweep_ctrl_pkg::FIELD_WIDTH,
    parameter int FIELD_HEIGHT = proj_sweep_ctrl_pkg::FIELD_HEIGHT,
    parameter int NUM_ITERS    = 40,
    parameter int ITER_W       = $clog2(NUM_ITERS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear_i,
    input  logic               step_i,
    output logic [COORD_W-1:0] x_o,
    output logic [COORD_W-1:0] y_o,
    output logic [ITER_W-1:0]  iter_o,
`ifdef RED_BLACK_EN
    output logic               pass_o,
`endif
    output logic               last_cell_o,
    output logic               last_of_solve_o
);

    localparam logic [COORD_W-1:0] X_LAST    = COORD_W'(FIELD_WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_LAST    = COORD_W'(FIELD_HEIGHT - 1);
    localparam logic [ITER_W-1:0]  ITER_LAST = ITER_W'(NUM_ITERS - 1);

    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic [ITER_W-1:0]  iter_q, iter_d;
    logic               row_end, col_end;

`ifdef RED_BLACK_EN
    logic pass_q, pass_d;

    // Checkerboard: two columns per step, each row starts on the column matching the pass parity.
    assign row_end = (x_q + COORD_W'(2)) > X_LAST;
    assign col_end = (y_q == Y_LAST);

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        iter_d = iter_q;
        pass_d = pass_q;
        if (clear_i) begin
            x_d    = '0;
            y_d    = '0;
            iter_d = '0;
            pass_d = 1'b0;
        end else if (step_i) begin
            if (!row_end) begin
                x_d = x_q + COORD_W'(2);
            end else if (!col_end) begin
                y_d = y_q + COORD_W'(1);
                x_d = {{(COORD_W-1){1'b0}}, ~(y_q[0] ^ pass_q)};
            end else begin
                y_d = '0;
                if (!pass_q) begin
                    pass_d = 1'b1;
                    x_d    = COORD_W'(1);
                end else begin
                    pass_d = 1'b0;
                    x_d    = '0;
                    iter_d = iter_q + ITER_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pass_q <= 1'b0;
        else     pass_q <= pass_d;
    end

    assign pass_o      = pass_q;
    assign last_cell_o = row_end && col_end && pass_q;
`else
    assign row_end = (x_q == X_LAST);
    assign col_end = (y_q == Y_LAST);

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        iter_d = iter_q;
        if (clear_i) begin
            x_d    = '0;
            y_d    = '0;
            iter_d = '0;
        end else if (step_i) begin
            if (!row_end) begin
                x_d = x_q + COORD_W'(1);
            end else begin
                x_d = '0;
                if (!col_end) begin
                    y_d = y_q + COORD_W'(1);
                end else begin
                    y_d    = '0;
                    iter_d = iter_q + ITER_W'(1);
                end
            end
        end
    end

    assign last_cell_o = row_end && col_end;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q    <= '0;
            y_q    <= '0;
            iter_q <= '0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            iter_q <= iter_d;
        end
    end

    assign x_o             = x_q;
    assign y_o             = y_q;
    assign iter_o          = iter_q;
    assign last_of_solve_o = last_cell_o && (iter_q == ITER_LAST);

endmodule

// File: rtl/proj_sweep_ctrl.sv
// Pressure-projection sweep sequencer: reader start/done, updater valid/ready, skip counting.
// Build option RED_BLACK_EN selects checkerboard ordering and adds the pass_o output.
module proj_sweep_ctrl
    import proj_sweep_ctrl_pkg::*;
#(
    parameter int FIELD_WIDTH  = proj_sweep_ctrl_pkg::FIELD_WIDTH,
    parameter int FIELD_HEIGHT = proj_sweep_ctrl_pkg::FIELD_HEIGHT,
    parameter int NUM_ITERS    = 40,
    parameter int ITER_W       = $clog2(NUM_ITERS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               go_i,
    input  logic               abort_i,
    output logic               busy_o,
    output logic               solve_done_o,
    output logic [ITER_W-1:0]  iter_idx_o,
    output logic [SKIP_W-1:0]  skip_cnt_o,
`ifdef RED_BLACK_EN
    output logic               pass_o,
`endif
    proj_sweep_ctrl_if.master  bus
);

    sweep_state_t       state_q, state_d;
    logic               abort_pend_q, abort_pend_d;
    logic [SKIP_W-1:0]  skip_q, skip_d;
    logic               clear, step;
    logic [COORD_W-1:0] cx, cy;
    logic               last_cell, last_of_solve;

    proj_sweep_ctrl_cell_iter #(
        .FIELD_WIDTH  (FIELD_WIDTH),
        .FIELD_HEIGHT (FIELD_HEIGHT),
        .NUM_ITERS    (NUM_ITERS),
        .ITER_W       (ITER_W)
    ) u_iter (
        .clk             (clk),
        .rst             (rst),
        .clear_i         (clear),
        .step_i          (step),
        .x_o             (cx),
        .y_o             (cy),
        .iter_o          (iter_idx_o),
`ifdef RED_BLACK_EN
        .pass_o          (pass_o),
`endif
        .last_cell_o     (last_cell),
        .last_of_solve_o (last_of_solve)
    );

    always_comb begin
        state_d      = state_q;
        abort_pend_d = abort_pend_q;
        skip_d       = skip_q;
        clear        = 1'b0;
        step         = 1'b0;
        case (state_q)
            IDLE: begin
                abort_pend_d = 1'b0;
                if (go_i) begin
                    state_d = ISSUE;
                    clear   = 1'b1;
                    skip_d  = '0;
                end
            end
            ISSUE: state_d = abort_i ? IDLE : WAIT_RD;
            WAIT_RD: begin
                // An abort here is parked until the reader finishes, so no done is left in flight.
                if (abort_i) abort_pend_d = 1'b1;
                if (bus.rd_done) begin
                    if (abort_i || abort_pend_q) begin
                        state_d = IDLE;
                    end else if (bus.rd_n == 3'd0) begin
                        state_d = ADVANCE;
                        skip_d  = sat_inc(skip_q);
                    end else begin
                        state_d = HANDOFF;
                    end
                end
            end
            HANDOFF: begin
                if (abort_i)            state_d = IDLE;
                else if (bus.upd_ready) state_d = ADVANCE;
            end
            ADVANCE: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (last_of_solve) begin
                    state_d = FIN;
                end else begin
                    step    = 1'b1;
                    state_d = ISSUE;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            abort_pend_q <= 1'b0;
            skip_q       <= '0;
        end else begin
            state_q      <= state_d;
            abort_pend_q <= abort_pend_d;
            skip_q       <= skip_d;
        end
    end

    assign busy_o        = (state_q == ISSUE) || (state_q == WAIT_RD) ||
                           (state_q == HANDOFF) || (state_q == ADVANCE);
    assign solve_done_o  = (state_q == FIN);
    assign skip_cnt_o    = skip_q;

    assign bus.field_x   = cx;
    assign bus.field_y   = cy;
    assign bus.rd_start  = (state_q == ISSUE);
    assign bus.upd_valid = (state_q == HANDOFF);
    assign bus.upd_x     = cx;
    assign bus.upd_y     = cy;
    assign bus.upd_last  = (state_q == HANDOFF) && last_of_solve;

endmodule

// File: tb/tb_proj_sweep_ctrl.sv
// Scoreboard bench for proj_sweep_ctrl: random reader latency, rd_n and updater back-pressure.
module tb_proj_sweep_ctrl;

    localparam int W   = 8;
    localparam int H   = 6;
    localparam int NI  = 2;
    localparam int ITW = $clog2(NI + 1);

    typedef struct { int x; int y; int it; int pass; int n; } visit_t;
    typedef struct { int x; int y; bit last; } upd_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           go;
    logic           abort;
    logic           busy, solve_done;
    logic [ITW-1:0] iter_idx;
    logic [15:0]    skip_cnt;
`ifdef RED_BLACK_EN
    logic           pass;
`endif

    proj_sweep_ctrl_if bus();

    proj_sweep_ctrl #(
        .FIELD_WIDTH (W),
        .FIELD_HEIGHT(H),
        .NUM_ITERS   (NI),
        .ITER_W      (ITW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .go_i        (go),
        .abort_i     (abort),
        .busy_o      (busy),
        .solve_done_o(solve_done),
        .iter_idx_o  (iter_idx),
        .skip_cnt_o  (skip_cnt),
`ifdef RED_BLACK_EN
        .pass_o      (pass),
`endif
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     errors = 0;
    visit_t exp_rd[$];
    upd_t   exp_upd[$];
    int     exp_skip;
    visit_t last_vis;
    int     rd_delay   = 3;
    int     ready_mode = 0;
    int     done_cnt   = 0;
    int     rd_starts  = 0;

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference visit order and expected handoffs for one whole solve.
    task automatic build_solve(input int zero_pct);
        visit_t v;
        upd_t   u;
        int     total, idx;
        exp_rd.delete();
        exp_upd.delete();
        exp_skip = 0;
        total = NI * W * H;
        idx = 0;
        for (int it = 0; it < NI; it++) begin
`ifdef RED_BLACK_EN
            for (int p = 0; p < 2; p++)
`else
            for (int p = 0; p < 1; p++)
`endif
                for (int y = 0; y < H; y++)
                    for (int x = 0; x < W; x++) begin
`ifdef RED_BLACK_EN
                        if (((x + y) % 2) != p) continue;
`endif
                        v.x = x; v.y = y; v.it = it; v.pass = p;
                        v.n = ($urandom_range(99) < zero_pct) ? 0 : int'($urandom_range(1, 4));
                        exp_rd.push_back(v);
                        idx++;
                        if (v.n == 0) exp_skip++;
                        else begin
                            u.x = x; u.y = y; u.last = (idx == total);
                            exp_upd.push_back(u);
                        end
                        last_vis = v;
                    end
        end
    endtask

    // Reader model: answers each rd_start after rd_delay cycles (0 = random 1..4).
    initial begin
        int     cnt;
        visit_t cur;
        cnt = 0;
        bus.rd_done = 1'b0;
        bus.rd_n    = 3'd0;
        forever begin
            @(negedge clk);
            if (bus.rd_done) bus.rd_done = 1'b0;
            if (cnt > 0 && busy) begin
                chk("rd_hold_x", bus.field_x, cur.x);
                chk("rd_hold_y", bus.field_y, cur.y);
            end
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    bus.rd_done = 1'b1;
                    bus.rd_n    = 3'(cur.n);
                end
            end
            if (bus.rd_start) begin
                rd_starts++;
                if (exp_rd.size() == 0) begin
                    chk("rd_unexpected_start", 1, 0);
                end else begin
                    cur = exp_rd.pop_front();
                    chk("rd_x", bus.field_x, cur.x);
                    chk("rd_y", bus.field_y, cur.y);
                    chk("rd_iter", iter_idx, cur.it);
`ifdef RED_BLACK_EN
                    chk("rd_pass", pass, cur.pass);
`endif
                    cnt = (rd_delay == 0) ? int'($urandom_range(1, 4)) : rd_delay;
                end
            end
        end
    end

    // Updater monitor: drives upd_ready, pops and compares accepted handoffs.
    initial begin
        bit   r, stall_v;
        int   sx, sy;
        upd_t u;
        stall_v = 1'b0;
        bus.upd_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (ready_mode)
                0:       r = 1'b1;
                1:       r = ($urandom_range(0, 3) != 0);
                default: r = 1'b0;
            endcase
            bus.upd_ready = r;
            if (solve_done) done_cnt++;
            if (bus.upd_valid) begin
                chk("no_rd_start_in_handoff", bus.rd_start, 0);
                if (stall_v) begin
                    chk("stall_x", bus.upd_x, sx);
                    chk("stall_y", bus.upd_y, sy);
                end
                if (r) begin
                    stall_v = 1'b0;
                    if (exp_upd.size() == 0) chk("upd_unexpected", 1, 0);
                    else begin
                        u = exp_upd.pop_front();
                        chk("upd_x", bus.upd_x, u.x);
                        chk("upd_y", bus.upd_y, u.y);
                        chk("upd_last", bus.upd_last, u.last);
                    end
                end else begin
                    stall_v = 1'b1;
                    sx = int'(bus.upd_x);
                    sy = int'(bus.upd_y);
                end
            end else begin
                stall_v = 1'b0;
            end
        end
    end

    task automatic run_solve(input int zpct, input int dly, input int rmode, input bit go_busy);
        int cyc, d0;
        build_solve(zpct);
        rd_delay   = dly;
        ready_mode = rmode;
        d0 = done_cnt;
        @(negedge clk); go = 1'b1;
        @(negedge clk); go = 1'b0;
        cyc = 1;
        while (!solve_done && cyc < 6000) begin
            @(negedge clk);
            cyc++;
            go = go_busy && (cyc == 50);
        end
        go = 1'b0;
        chk("solve_timeout", (cyc < 6000), 1);
        if (zpct == 0 && dly == 3 && rmode == 0)
            chk("solve_latency_in_window", (cyc >= 288*NI - 2 && cyc <= 288*NI + 2), 1);
        chk("done_busy_low", busy, 0);
        chk("final_iter", iter_idx, NI - 1);
        chk("final_x", bus.field_x, last_vis.x);
        chk("final_y", bus.field_y, last_vis.y);
        chk("skip_cnt", skip_cnt, exp_skip);
        @(negedge clk);
        chk("done_pulse_count", done_cnt - d0, 1);
        chk("solve_done_one_cycle", solve_done, 0);
        chk("rd_left", exp_rd.size(), 0);
        chk("upd_left", exp_upd.size(), 0);
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, solve_done, 0);
        chk({tag, "_x"}, bus.field_x, 0);
        chk({tag, "_y"}, bus.field_y, 0);
        chk({tag, "_iter"}, iter_idx, 0);
        chk({tag, "_skip"}, skip_cnt, 0);
        chk({tag, "_rd_start"}, bus.rd_start, 0);
        chk({tag, "_upd_valid"}, bus.upd_valid, 0);
        chk({tag, "_upd_last"}, bus.upd_last, 0);
    endtask

    initial begin
        int n, d0;
        rst = 1'b1; go = 1'b0; abort = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        rst = 1'b0;

        // Nominal throughput: fixed 3-cycle reader, no skips, no stalls, go pulsed while busy.
        run_solve(0, 3, 0, 1'b1);
        n = rd_starts;
        run_solve(25, 0, 1, 1'b1);
        chk("rd_start_count", rd_starts - n, NI * W * H);
        run_solve(100, 0, 0, 1'b0);

        // Abort while waiting on a 5-cycle reader: stays busy until rd_done, then idle.
        build_solve(0);
        rd_delay = 5; ready_mode = 0; d0 = done_cnt;
        @(negedge clk); go = 1'b1;
        @(negedge clk); go = 1'b0;
        n = 0;
        while (n < 3 && busy) begin
            @(negedge clk);
            if (bus.rd_start) n++;
        end
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        n = 0;
        while (!bus.rd_done && n < 20) begin
            chk("abort_wait_busy", busy, 1);
            @(negedge clk);
            n++;
        end
        chk("abort_wait_bounded", (n < 20), 1);
        @(negedge clk);
        chk("abort_idle_after_done", busy, 0);
        chk("abort_no_valid", bus.upd_valid, 0);
        repeat (3) @(negedge clk);
        chk("abort_no_solve_done", done_cnt - d0, 0);
        run_solve(10, 0, 1, 1'b0);

        // Abort during a stalled handoff drops upd_valid on the next cycle.
        build_solve(0);
        rd_delay = 2; ready_mode = 2;
        @(negedge clk); go = 1'b1;
        @(negedge clk); go = 1'b0;
        n = 0;
        while (!bus.upd_valid && n < 50) begin @(negedge clk); n++; end
        chk("handoff_reached", bus.upd_valid, 1);
        repeat (10) @(negedge clk);
        chk("stall_still_valid", bus.upd_valid, 1);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("handoff_abort_busy", busy, 0);
        chk("handoff_abort_valid", bus.upd_valid, 0);
        ready_mode = 0;
        repeat (3) @(negedge clk);
        run_solve(0, 0, 0, 1'b0);

        // Asynchronous reset mid-solve.
        build_solve(0);
        rd_delay = 0; ready_mode = 1;
        @(negedge clk); go = 1'b1;
        @(negedge clk); go = 1'b0;
        repeat (77) @(negedge clk);
        chk("pre_reset_busy", busy, 1);
        #2 rst = 1'b1;
        #1 check_idle_zero("async_reset");
        @(negedge clk); rst = 1'b0;
        repeat (10) @(negedge clk);
        run_solve(20, 0, 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
